// File: rtl/ps2_pkg.sv
// Shared PS/2 constants and the scan code set 2 to ASCII lookup used by the
// receiver and the keyboard decoder.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BRK    = 8'hF0;
   localparam int         FRAME_BITS = 11;

   // Unmapped codes fall through to 0x00 so the display shows a blank character.
   function automatic logic [7:0] scan_to_ascii(input logic [7:0] code);
      logic [7:0] ascii;
      ascii = 8'h00;
      case (code)
         8'h1C: ascii = 8'h61; 8'h32: ascii = 8'h62; 8'h21: ascii = 8'h63;
         8'h23: ascii = 8'h64; 8'h24: ascii = 8'h65; 8'h2B: ascii = 8'h66;
         8'h34: ascii = 8'h67; 8'h33: ascii = 8'h68; 8'h43: ascii = 8'h69;
         8'h3B: ascii = 8'h6A; 8'h42: ascii = 8'h6B; 8'h4B: ascii = 8'h6C;
         8'h3A: ascii = 8'h6D; 8'h31: ascii = 8'h6E; 8'h44: ascii = 8'h6F;
         8'h4D: ascii = 8'h70; 8'h15: ascii = 8'h71; 8'h2D: ascii = 8'h72;
         8'h1B: ascii = 8'h73; 8'h2C: ascii = 8'h74; 8'h3C: ascii = 8'h75;
         8'h2A: ascii = 8'h76; 8'h1D: ascii = 8'h77; 8'h22: ascii = 8'h78;
         8'h35: ascii = 8'h79; 8'h1A: ascii = 8'h7A;
         8'h45: ascii = 8'h30; 8'h16: ascii = 8'h31; 8'h1E: ascii = 8'h32;
         8'h26: ascii = 8'h33; 8'h25: ascii = 8'h34; 8'h2E: ascii = 8'h35;
         8'h36: ascii = 8'h36; 8'h3D: ascii = 8'h37; 8'h3E: ascii = 8'h38;
         8'h46: ascii = 8'h39;
         8'h29: ascii = 8'h20; 8'h5A: ascii = 8'h0D; 8'h66: ascii = 8'h08;
         default: ascii = 8'h00;
      endcase
      return ascii;
   endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: synchronises the raw lines, shifts bits in
// on ps2_clk falling edges and emits one pulse per valid frame.
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       byte_valid,
   output logic [7:0] byte_data
);

   localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   logic [1:0] line_raw;
   logic [1:0] line_sync;
   logic       ps2_clk_hist_reg;
   logic       fall;
   logic       timeout_hit;

   logic [FRAME_BITS-1:0] shift_reg;
   logic [FRAME_BITS-1:0] frame_next;
   logic [3:0]            bit_cnt_reg;
   logic [TO_W-1:0]       idle_cnt_reg;
   logic                  byte_valid_reg;
   logic [7:0]            byte_data_reg;
   logic                  frame_ok;

   assign line_raw = {ps2_data, ps2_clk};

   // Index 0 is ps2_clk, index 1 is ps2_data; both idle high out of reset.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_sync
         logic [1:0] sync_reg;
         always_ff @(posedge clk) begin
            if (!resetn) sync_reg <= 2'b11;
            else         sync_reg <= {sync_reg[0], line_raw[gi]};
         end
         assign line_sync[gi] = sync_reg[1];
      end
   endgenerate

   assign fall       = ps2_clk_hist_reg & ~line_sync[0];
   assign frame_next = {line_sync[1], shift_reg[FRAME_BITS-1:1]};
   // start low, stop high, odd parity over data+parity bits
   assign frame_ok   = ~frame_next[0] & frame_next[10] & (^frame_next[9:1]);

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_timeout
         assign timeout_hit = (bit_cnt_reg != 4'd0) &&
                              (idle_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
      end else begin : g_no_timeout
         assign timeout_hit = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!resetn) begin
         ps2_clk_hist_reg <= 1'b1;
         shift_reg        <= '0;
         bit_cnt_reg      <= 4'd0;
         idle_cnt_reg     <= '0;
         byte_valid_reg   <= 1'b0;
         byte_data_reg    <= 8'h00;
      end else begin
         ps2_clk_hist_reg <= line_sync[0];
         byte_valid_reg   <= 1'b0;
         if (fall) begin
            shift_reg    <= frame_next;
            idle_cnt_reg <= '0;
            if (bit_cnt_reg == 4'(FRAME_BITS - 1)) begin
               bit_cnt_reg <= 4'd0;
               if (frame_ok) begin
                  byte_valid_reg <= 1'b1;
                  byte_data_reg  <= frame_next[8:1];
               end
            end else begin
               bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end
         end else if (timeout_hit) begin
            bit_cnt_reg  <= 4'd0;
            idle_cnt_reg <= '0;
         end else if (bit_cnt_reg != 4'd0) begin
            idle_cnt_reg <= idle_cnt_reg + TO_W'(1);
         end
      end
   end

   assign byte_valid = byte_valid_reg;
   assign byte_data  = byte_data_reg;

endmodule

// File: rtl/ps2_keyboard_decoder.sv
// PS/2 keyboard decoder: interprets make/break/extended sequences from ps2_rx
// and holds the last make code, its ASCII form and a key-held flag.
module ps2_keyboard_decoder
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] ps2_scanout,
   output logic [7:0] ps2_out,
   output logic       putdown
);

   logic       byte_valid;
   logic [7:0] byte_data;

   logic       brk_reg,      brk_next;
   logic       ext_reg,      ext_next;
   logic [7:0] scan_reg,     scan_next;
   logic [7:0] ascii_reg,    ascii_next;
   logic       putdown_reg,  putdown_next;

   ps2_rx #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_rx (
      .clk       (clk),
      .resetn    (resetn),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .byte_valid(byte_valid),
      .byte_data (byte_data)
   );

   always_comb begin
      brk_next     = brk_reg;
      ext_next     = ext_reg;
      scan_next    = scan_reg;
      ascii_next   = ascii_reg;
      putdown_next = putdown_reg;
      if (byte_valid) begin
         if (byte_data == PS2_EXT) begin
            ext_next = 1'b1;
         end else if (byte_data == PS2_BRK) begin
            brk_next = 1'b1;
         end else if (!brk_reg) begin
            scan_next    = byte_data;
            ascii_next   = ext_reg ? 8'h00 : scan_to_ascii(byte_data);
            putdown_next = 1'b1;
            ext_next     = 1'b0;
         end else begin
            // Releasing a key other than the displayed one leaves the flag alone.
            if (byte_data == scan_reg) putdown_next = 1'b0;
            brk_next = 1'b0;
            ext_next = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         brk_reg     <= 1'b0;
         ext_reg     <= 1'b0;
         scan_reg    <= 8'h00;
         ascii_reg   <= 8'h00;
         putdown_reg <= 1'b0;
      end else begin
         brk_reg     <= brk_next;
         ext_reg     <= ext_next;
         scan_reg    <= scan_next;
         ascii_reg   <= ascii_next;
         putdown_reg <= putdown_next;
      end
   end

   assign ps2_scanout = scan_reg;
   assign ps2_out     = ascii_reg;
   assign putdown     = putdown_reg;

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Directed bench for ps2_keyboard_decoder: sends hand-built PS/2 frames and
// compares the registered outputs against hand-computed values.
module tb_ps2_keyboard_decoder;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] ps2_scanout;
   logic [7:0] ps2_out;
   logic       putdown;

   int checks = 0;
   int errors = 0;

   ps2_keyboard_decoder #(
      .TIMEOUT_CYCLES(100)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .ps2_scanout(ps2_scanout),
      .ps2_out    (ps2_out),
      .putdown    (putdown)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, observed, expected);
      end else begin
         $display("ok   %s: %h", tag, observed);
      end
   endtask

   // start, data LSB first, parity (odd unless flipped), stop
   function automatic logic [10:0] make_frame(input logic [7:0] data, input logic bad_parity);
      logic par;
      par = ~(^data) ^ bad_parity;
      return {1'b1, par, data, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] frame, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ps2_data = frame[i];
         repeat (2) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (4) @(negedge clk);
         ps2_clk = 1'b1;
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic send_byte(input logic [7:0] data);
      send_bits(make_frame(data, 1'b0), 11);
   endtask

   task automatic check_outputs(input string tag, input logic [7:0] scan,
                                input logic [7:0] ascii, input logic held);
      check({tag, ".scan"}, ps2_scanout, scan);
      check({tag, ".ascii"}, ps2_out, ascii);
      check({tag, ".putdown"}, {7'd0, putdown}, {7'd0, held});
   endtask

   initial begin
      logic [10:0] frame;

      // Reset
      repeat (2) @(negedge clk);
      #1;
      check_outputs("reset", 8'h00, 8'h00, 1'b0);
      resetn = 1'b1;
      repeat (3) @(negedge clk);

      // Make 0x1C with explicit 4-edge latency on the stop bit
      frame = make_frame(8'h1C, 1'b0);
      send_bits(frame, 10);
      @(negedge clk);
      ps2_data = frame[10];
      repeat (2) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("latency.edge3.scan", ps2_scanout, 8'h00);
      @(posedge clk);
      #1;
      check_outputs("make_1c", 8'h1C, 8'h61, 1'b1);
      repeat (4) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (2) @(negedge clk);

      // Break: nothing changes after F0 alone
      send_byte(8'hF0);
      check_outputs("after_f0", 8'h1C, 8'h61, 1'b1);
      send_byte(8'h1C);
      check_outputs("break_1c", 8'h1C, 8'h61, 1'b0);

      // Bad parity then good 0x16
      send_bits(make_frame(8'h16, 1'b1), 11);
      check_outputs("bad_parity", 8'h1C, 8'h61, 1'b0);
      send_byte(8'h16);
      check_outputs("make_16", 8'h16, 8'h31, 1'b1);

      // Rollover
      send_byte(8'h1C);
      check_outputs("make_1c_again", 8'h1C, 8'h61, 1'b1);
      send_byte(8'h32);
      check_outputs("rollover_32", 8'h32, 8'h62, 1'b1);
      send_byte(8'hF0);
      send_byte(8'h1C);
      check_outputs("old_break", 8'h32, 8'h62, 1'b1);

      // Extended make and break
      send_byte(8'hE0);
      check_outputs("after_e0", 8'h32, 8'h62, 1'b1);
      send_byte(8'h75);
      check_outputs("ext_make_75", 8'h75, 8'h00, 1'b1);
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h75);
      check_outputs("ext_break_75", 8'h75, 8'h00, 1'b0);

      // Ext flag must not leak into the next plain make
      send_byte(8'h5A);
      check_outputs("make_enter", 8'h5A, 8'h0D, 1'b1);

      // Timeout discards a partial frame
      send_bits(make_frame(8'h45, 1'b0), 5);
      repeat (150) @(negedge clk);
      send_byte(8'h45);
      check_outputs("timeout_45", 8'h45, 8'h30, 1'b1);

      // Reset mid-frame discards a partial frame
      send_bits(make_frame(8'h45, 1'b0), 5);
      @(negedge clk);
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_outputs("midframe_reset", 8'h00, 8'h00, 1'b0);
      resetn = 1'b1;
      @(negedge clk);
      send_byte(8'h45);
      check_outputs("reset_45", 8'h45, 8'h30, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
